// File: rtl/sens_par12_rcv.sv
// Front-end receiver for the 12-bit parallel sensor port: turns raw BPF/HACT/VACT
// strobes into a framed pixel stream with indices, markers, geometry and sticky error flags.
module sens_par12_rcv #(
    parameter int DATA_WIDTH = 12,
    parameter int COL_BITS   = 12,
    parameter int ROW_BITS   = 12,
    parameter int PASS_BPF   = 0
) (
    input  logic                  pclk,
    input  logic                  prst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] ipx,
    input  logic                  ibpf,
    input  logic                  ihact,
    input  logic                  ivact,
    output logic [DATA_WIDTH-1:0] pxd,
    output logic                  pxd_valid,
    output logic                  bpf_valid,
    output logic                  sof,
    output logic                  eol,
    output logic                  eof,
    output logic [COL_BITS-1:0]   col,
    output logic [ROW_BITS-1:0]   row,
    output logic                  frame_busy,
    output logic [COL_BITS-1:0]   last_width,
    output logic [ROW_BITS-1:0]   last_height,
    output logic                  err_width,
    output logic                  err_sync
);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_ARMED, ST_FRAME} state_t;

    state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0] r1_px_reg, r2_px_reg;
    logic r1_bpf_reg, r1_hact_reg, r1_vact_reg;
    logic r2_bpf_reg, r2_hact_reg, r2_vact_reg;

    logic [DATA_WIDTH-1:0] pxd_reg;
    logic                  pxd_valid_reg, bpf_valid_reg;
    logic                  sof_reg, eol_reg, eof_reg;
    logic [COL_BITS-1:0]   col_reg, last_width_reg;
    logic [ROW_BITS-1:0]   row_reg, last_height_reg, line_cnt_reg;
    logic                  frame_busy_reg, first_line_reg;
    logic                  err_width_reg, err_sync_reg;

    logic                  in_frame, pix_hact, pix_bpf;
    logic                  sof_next, eol_next, eof_next, sync_hit, first_line;
    logic [COL_BITS-1:0]   col_inc, col_next, line_width;
    logic [ROW_BITS-1:0]   row_inc, line_base, line_cnt_next;

    // Two-stage pin pipeline; r1 doubles as one-cycle lookahead for r2.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r1_px_reg   <= '0;
            r1_bpf_reg  <= 1'b0;
            r1_hact_reg <= 1'b0;
            r1_vact_reg <= 1'b0;
            r2_px_reg   <= '0;
            r2_bpf_reg  <= 1'b0;
            r2_hact_reg <= 1'b0;
            r2_vact_reg <= 1'b0;
        end else begin
            r1_px_reg   <= ipx;
            r1_bpf_reg  <= ibpf;
            r1_hact_reg <= ihact;
            r1_vact_reg <= ivact;
            r2_px_reg   <= r1_px_reg;
            r2_bpf_reg  <= r1_bpf_reg;
            r2_hact_reg <= r1_hact_reg;
            r2_vact_reg <= r1_vact_reg;
        end
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (en) state_next = ST_SYNC;
            end
            ST_SYNC: begin
                if (!en)              state_next = ST_IDLE;
                else if (!r1_vact_reg) state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (!en)                              state_next = ST_IDLE;
                else if (r1_vact_reg && !r2_vact_reg) state_next = ST_FRAME;
            end
            ST_FRAME: begin
                // A frame always runs to its VACT fall, even if en drops.
                if (r2_vact_reg && !r1_vact_reg) state_next = en ? ST_ARMED : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_frame  = (state_reg == ST_FRAME);
        pix_hact  = in_frame && r2_hact_reg && !r2_bpf_reg;
        pix_bpf   = in_frame && r2_bpf_reg && !r2_hact_reg && (PASS_BPF != 0);
        sof_next  = in_frame && !frame_busy_reg;
        eol_next  = pix_hact && !r1_hact_reg;
        eof_next  = in_frame && r2_vact_reg && !r1_vact_reg;
        sync_hit  = ((state_reg == ST_FRAME) || (state_reg == ST_ARMED)) &&
                    ((!r2_vact_reg && (r2_hact_reg || r2_bpf_reg)) || (r2_hact_reg && r2_bpf_reg));

        col_inc = (&col_reg) ? col_reg : col_reg + 1'b1;
        row_inc = (&row_reg) ? row_reg : row_reg + 1'b1;

        // A run continues only if the previous output pixel was of the same kind.
        col_next = '0;
        if (pix_hact)     col_next = pxd_valid_reg ? col_inc : '0;
        else if (pix_bpf) col_next = bpf_valid_reg ? col_inc : '0;

        line_width    = (&col_next) ? col_next : col_next + 1'b1;
        first_line    = sof_next || first_line_reg;
        line_base     = sof_next ? '0 : line_cnt_reg;
        line_cnt_next = (eol_next && !(&line_base)) ? line_base + 1'b1 : line_base;
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            pxd_reg         <= '0;
            pxd_valid_reg   <= 1'b0;
            bpf_valid_reg   <= 1'b0;
            sof_reg         <= 1'b0;
            eol_reg         <= 1'b0;
            eof_reg         <= 1'b0;
            col_reg         <= '0;
            row_reg         <= '0;
            frame_busy_reg  <= 1'b0;
            line_cnt_reg    <= '0;
            first_line_reg  <= 1'b0;
            last_width_reg  <= '0;
            last_height_reg <= '0;
            err_width_reg   <= 1'b0;
            err_sync_reg    <= 1'b0;
        end else begin
            pxd_reg        <= (pix_hact || pix_bpf) ? r2_px_reg : '0;
            pxd_valid_reg  <= pix_hact;
            bpf_valid_reg  <= pix_bpf;
            sof_reg        <= sof_next;
            eol_reg        <= eol_next;
            eof_reg        <= eof_next;
            col_reg        <= col_next;
            row_reg        <= sof_next ? '0 : (eol_reg ? row_inc : row_reg);
            frame_busy_reg <= sof_next || (frame_busy_reg && !eof_reg);
            line_cnt_reg   <= line_cnt_next;
            if (sof_next) first_line_reg <= 1'b1;
            if (eol_next) first_line_reg <= 1'b0;
            if (eol_next && first_line) last_width_reg <= line_width;
            if (eof_next) last_height_reg <= line_cnt_next;
            err_width_reg  <= (err_width_reg && !sof_next) ||
                              (eol_next && !first_line && (line_width != last_width_reg));
            err_sync_reg   <= (err_sync_reg && !sof_next) || sync_hit;
        end
    end

    assign pxd         = pxd_reg;
    assign pxd_valid   = pxd_valid_reg;
    assign bpf_valid   = bpf_valid_reg;
    assign sof         = sof_reg;
    assign eol         = eol_reg;
    assign eof         = eof_reg;
    assign col         = col_reg;
    assign row         = row_reg;
    assign frame_busy  = frame_busy_reg;
    assign last_width  = last_width_reg;
    assign last_height = last_height_reg;
    assign err_width   = err_width_reg;
    assign err_sync    = err_sync_reg;

endmodule

// File: doc/sens_par12_rcv.md
# sens_par12_rcv

Synthesizable receiver for the 12-bit parallel sensor port: D[11:0], BPF, HACT and VACT, sampled on the sensor pixel clock. It sits at the front of a sensor channel. It converts the raw strobes into a framed pixel stream with per-pixel column/row indices, start/end markers, measured frame geometry and sticky protocol-error flags. Its bench stimulus is the existing 12-bit sensor simulation model.

## Interface
- DATA_WIDTH, 12, pixel data width
- COL_BITS, 12, width of column counter and width result
- ROW_BITS, 12, width of row counter and height result
- PASS_BPF, 0, 1: black pixels (BPF) are output with bpf_valid; 0: they are dropped

- pclk  in  1  pixel clock; all logic on rising edge
- prst  in  1  asynchronous active-high reset
- en  in  1  capture enable (level)
- ipx  in  DATA_WIDTH  sensor data pins
- ibpf  in  1  black pixel flag pin
- ihact  in  1  horizontal active pin
- ivact  in  1  vertical active pin
- pxd  out  DATA_WIDTH  output pixel
- pxd_valid  out  1  pxd is an active (HACT) pixel
- bpf_valid  out  1  pxd is a black pixel (only when PASS_BPF=1)
- sof  out  1  one-cycle start of frame
- eol  out  1  one-cycle, coincident with the last HACT pixel of a line
- eof  out  1  one-cycle, last VACT-high cycle of the frame
- col  out  COL_BITS  index of pxd within its line, 0-based
- row  out  ROW_BITS  index of current line, 0-based
- frame_busy  out  1  a frame is being received
- last_width  out  COL_BITS  HACT pixel count of the first line of the last frame
- last_height  out  ROW_BITS  line count of the last completed frame
- err_width  out  1  sticky: a line differed from the first line's width
- err_sync  out  1  sticky: HACT or BPF seen outside VACT, or HACT and BPF both high

## Operation
- Input pipeline: r1 registers the pins; r2 registers r1. Outputs are registered from r2, with r1 used as one-cycle lookahead.
- States:
  - IDLE: waiting for en.
  - SYNC: waiting for r1.vact=0, so a partial frame is never accepted.
  - ARMED: waiting for r1.vact rising.
  - FRAME: receiving.
- Transitions:
  - IDLE->SYNC when en=1.
  - SYNC->ARMED when r1.vact=0.
  - ARMED->FRAME on r1.vact 0->1.
  - FRAME->ARMED on r1.vact 1->0 when en=1; FRAME->IDLE on that edge when en=0.
  - en deassertion never aborts a frame mid-way.
  - en=0 in SYNC or ARMED returns to IDLE next cycle.
- In FRAME:
  - pxd_valid = r2.hact.
  - bpf_valid = r2.bpf & PASS_BPF.
  - pxd = r2 data when either valid is set, else 0.
- col:
  - Resets to 0 on the first pixel of each HACT run and increments per HACT pixel.
  - Saturates at all-ones.
  - BPF pixels carry their own col count, restarting at 0.
- row starts at 0 on sof and increments on the cycle after eol. It saturates.
- eol = r2.hact & !r1.hact.
- Width check:
  - The first line's width is latched into last_width at its eol.
  - Any later line whose width differs sets err_width.
- eof = r2.vact & !r1.vact. At eof, last_height is loaded with the number of eols in the frame.
- sof is asserted in the output cycle in which r2.vact first goes high in FRAME. err_width and err_sync clear on sof.
- err_sync is set when r2.hact or r2.bpf is high while r2.vact is low in FRAME or ARMED, or when r2.hact & r2.bpf. Offending pixels are not output.

## Timing
- Latency is 3 pclk from pin to pxd, pxd_valid, bpf_valid, col, sof, eol and eof.
- frame_busy rises with sof and falls the cycle after eof.
- Simultaneous events:
  - HACT and VACT falling in the same pin cycle: eol and eof in the same output cycle, and last_height counts that line.
  - VACT rising with HACT already high: sof and the first pixel in the same cycle, col=0.
- Reset:
  - All outputs are 0, and state is IDLE.
  - Reset mid-frame discards the frame; last_width and last_height read 0.
- No back-pressure: the downstream stage must accept one pixel per pclk.

## Test plan
- Simulator stream, ncols=66, nrows=18, nbpf=20, lline=192, en=1, PASS_BPF=0 -> one sof; 18 eols; 66 pxd_valid per line with col 0..65; eof; last_width=66, last_height=18; no errors.
- en asserted with ivact already high -> rest of the current frame ignored; the first sof comes at the next VACT rise.
- PASS_BPF=1 -> 20 bpf_valid per line with col 0..19, followed by 66 pxd_valid.
- Line 5 forced to 65 pixels -> err_width=1 after that eol and stays 1 until the next sof; last_width=66.
- HACT pulse while VACT=0 -> err_sync=1 and no pxd_valid. HACT and VACT falling together on the last line -> eol and eof coincide.
- prst pulse mid-frame -> all outputs 0 immediately. With en=1 after reset, capture resumes at the next full frame.
